// File: rtl/imem.sv
// Instruction memory (512x32) with boot-image preload and registered RV32I field decode.
// Optional feature macro: IMEM_MISALIGN_TRAP_EN adds the inst_misaligned output.
module imem #(
    parameter int unsigned ADDR_W   = 11,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] inst_mem_addr,
    input  logic              imem_enable,
    input  logic              load_imem,
    output logic [4:0]        rs1_address,
    output logic [4:0]        rs2_address,
    output logic [4:0]        rd_address,
    output logic [31:0]       imm_decode,
`ifdef IMEM_MISALIGN_TRAP_EN
    output logic              inst_misaligned,
`endif
    output logic [31:0]       inst_CCD
);

    localparam int unsigned IDX_W     = ADDR_W - 2;
    localparam int unsigned DEPTH     = 2 ** IDX_W;
    localparam int unsigned BOOT_LEN  = 8;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    logic [31:0] mem_q [DEPTH];

    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] inst_q, inst_d;
    logic        mis_q, mis_d;

    logic [IDX_W-1:0] word_idx_c;
    logic [31:0]      fetch_c;
    logic [31:0]      imm_c;
    logic             misaligned_c;
    logic             read_c;
    logic             load_c;

    function automatic logic [31:0] boot_word(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(0): boot_word = 32'h0050_0093;
            IDX_W'(1): boot_word = 32'h00A0_0113;
            IDX_W'(2): boot_word = 32'h0020_81B3;
            IDX_W'(3): boot_word = 32'h0030_2223;
            IDX_W'(4): boot_word = 32'h0040_2203;
            IDX_W'(5): boot_word = 32'h0041_8463;
            IDX_W'(6): boot_word = 32'h1234_52B7;
            IDX_W'(7): boot_word = 32'h0000_006F;
            default:   boot_word = NOP_WORD;
        endcase
    endfunction

    assign load_c = imem_enable & load_imem;
    assign read_c = imem_enable & ~load_imem;

    // Whole-array preload in one edge; deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (load_c) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[IDX_W'(i)] <= (i < BOOT_LEN) ? boot_word(IDX_W'(i)) : NOP_WORD;
            end
        end
    end

    // Fetch word; a misaligned read is replaced by a NOP when the trap is built in.
    always_comb begin
        word_idx_c   = inst_mem_addr[ADDR_W-1:2];
`ifdef IMEM_MISALIGN_TRAP_EN
        misaligned_c = (inst_mem_addr[1:0] != 2'b00);
`else
        misaligned_c = 1'b0;
`endif
        fetch_c      = misaligned_c ? NOP_WORD : mem_q[word_idx_c];
    end

    // Immediate select by opcode.
    always_comb begin
        imm_c = 32'h0;
        case (fetch_c[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm_c = {{20{fetch_c[31]}}, fetch_c[31:20]};
            OP_STORE:
                imm_c = {{20{fetch_c[31]}}, fetch_c[31:25], fetch_c[11:7]};
            OP_BRANCH:
                imm_c = {{19{fetch_c[31]}}, fetch_c[31], fetch_c[7],
                         fetch_c[30:25], fetch_c[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_c = {fetch_c[31:12], 12'h000};
            OP_JAL:
                imm_c = {{11{fetch_c[31]}}, fetch_c[31], fetch_c[19:12],
                         fetch_c[20], fetch_c[30:21], 1'b0};
            default:
                imm_c = 32'h0;
        endcase
    end

    // Output registers update only on read cycles; load and disabled cycles hold.
    always_comb begin
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        rd_d   = rd_q;
        imm_d  = imm_q;
        inst_d = inst_q;
        mis_d  = mis_q;
        if (read_c) begin
            rs1_d  = fetch_c[19:15];
            rs2_d  = fetch_c[24:20];
            rd_d   = fetch_c[11:7];
            imm_d  = imm_c;
            inst_d = fetch_c;
            mis_d  = misaligned_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q  <= 5'h0;
            rs2_q  <= 5'h0;
            rd_q   <= 5'h0;
            imm_q  <= 32'h0;
            inst_q <= 32'h0;
            mis_q  <= 1'b0;
        end else begin
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
            imm_q  <= imm_d;
            inst_q <= inst_d;
            mis_q  <= mis_d;
        end
    end

    assign rs1_address = rs1_q;
    assign rs2_address = rs2_q;
    assign rd_address  = rd_q;
    assign imm_decode  = imm_q;
    assign inst_CCD    = inst_q;
`ifdef IMEM_MISALIGN_TRAP_EN
    assign inst_misaligned = mis_q;
`else
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_imem.sv
// Table-driven, scoreboarded bench for imem (boot-image decode, latency, hold, reset).
module tb_imem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] inst_mem_addr;
    logic        imem_enable;
    logic        load_imem;
    logic [4:0]  rs1_address, rs2_address, rd_address;
    logic [31:0] imm_decode, inst_CCD;
    logic        mis_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        mis;
    } rec_t;

    rec_t vec [12];
    rec_t exp_q [$];

    imem dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_mem_addr (inst_mem_addr),
        .imem_enable   (imem_enable),
        .load_imem     (load_imem),
        .rs1_address   (rs1_address),
        .rs2_address   (rs2_address),
        .rd_address    (rd_address),
        .imm_decode    (imm_decode),
`ifdef IMEM_MISALIGN_TRAP_EN
        .inst_misaligned (mis_out),
`endif
        .inst_CCD      (inst_CCD)
    );

`ifndef IMEM_MISALIGN_TRAP_EN
    assign mis_out = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_rec(input string name, input rec_t e);
        checks++;
        if (inst_CCD !== e.inst || rs1_address !== e.rs1 || rs2_address !== e.rs2 ||
            rd_address !== e.rd || imm_decode !== e.imm || mis_out !== e.mis) begin
            errors++;
            $display("FAIL %s: got inst=%h rs1=%0d rs2=%0d rd=%0d imm=%h mis=%b, want inst=%h rs1=%0d rs2=%0d rd=%0d imm=%h mis=%b",
                     name, inst_CCD, rs1_address, rs2_address, rd_address, imm_decode, mis_out,
                     e.inst, e.rs1, e.rs2, e.rd, e.imm, e.mis);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a read, push its expectation, and check it after the following edge.
    task automatic read_and_check(input string name, input rec_t e);
        rec_t got;
        inst_mem_addr = e.addr;
        imem_enable   = 1'b1;
        load_imem     = 1'b0;
        exp_q.push_back(e);
        step();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got inst=%h want an entry", name, inst_CCD);
        end else begin
            got = exp_q.pop_front();
            check_rec(name, got);
        end
    endtask

    initial begin
        rec_t zero_r, w1, w6, w0;
        logic mis_exp;

`ifdef IMEM_MISALIGN_TRAP_EN
        mis_exp = 1'b1;
`else
        mis_exp = 1'b0;
`endif
        zero_r = '{11'h000, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0};
        w0     = '{11'h000, 32'h0050_0093, 5'd0, 5'd5,  5'd1, 32'd5,  1'b0};
        w1     = '{11'h004, 32'h00A0_0113, 5'd0, 5'd10, 5'd2, 32'd10, 1'b0};
        w6     = '{11'h018, 32'h1234_52B7, 5'd8, 5'd3,  5'd5, 32'h1234_5000, 1'b0};

        vec[0]  = w0;
        vec[1]  = w1;
        vec[2]  = '{11'h008, 32'h0020_81B3, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0};
        vec[3]  = '{11'h00C, 32'h0030_2223, 5'd0, 5'd3, 5'd4, 32'd4, 1'b0};
        vec[4]  = '{11'h010, 32'h0040_2203, 5'd0, 5'd4, 5'd4, 32'd4, 1'b0};
        vec[5]  = '{11'h014, 32'h0041_8463, 5'd3, 5'd4, 5'd8, 32'd8, 1'b0};
        vec[6]  = w6;
        vec[7]  = '{11'h01C, 32'h0000_006F, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0};
        vec[8]  = '{11'h7FC, 32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0};
        vec[9]  = '{11'h020, 32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0};
        vec[10] = '{11'h3FD, 32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'd0, mis_exp};
        if (mis_exp)
            vec[11] = '{11'h006, 32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1};
        else
            vec[11] = '{11'h006, 32'h00A0_0113, 5'd0, 5'd10, 5'd2, 32'd10, 1'b0};

        rst_n = 1'b0;
        inst_mem_addr = 11'h000;
        imem_enable = 1'b0;
        load_imem = 1'b0;
        #1;
        check_rec("reset_initial", zero_r);

        step();
        rst_n = 1'b1;
        // Disabled with load requested: no load, outputs hold at zero.
        imem_enable = 1'b0;
        load_imem = 1'b1;
        repeat (3) step();
        check_rec("disabled_load_hold", zero_r);

        // Load cycles keep outputs held.
        imem_enable = 1'b1;
        load_imem = 1'b1;
        repeat (4) step();
        check_rec("load_cycles_hold", zero_r);

        // Back-to-back reads across the table.
        for (int i = 0; i < 12; i++) begin
            read_and_check($sformatf("vec%0d_addr%h", i, vec[i].addr), vec[i]);
        end

        read_and_check("pre_disable_u", w6);

        // Address changes while disabled are ignored.
        imem_enable = 1'b0;
        load_imem = 1'b1;
        inst_mem_addr = 11'h000;
        repeat (3) step();
        check_rec("disabled_addr_hold", w6);

        // Repeated load with nonzero outputs: outputs hold, contents unchanged.
        imem_enable = 1'b1;
        load_imem = 1'b1;
        step();
        check_rec("reload_hold", w6);
        read_and_check("after_reload_w0", w0);

        // Asynchronous reset between edges clears outputs immediately.
        rst_n = 1'b0;
        #1;
        check_rec("async_reset_midcycle", zero_r);
        #1;
        rst_n = 1'b1;

        // Array contents survive reset.
        read_and_check("post_reset_array_kept", w1);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
